// File: rtl/blockade_clk_pkg.sv
// Shared types and default constants for the clock-enable / reset generator.
package blockade_clk_pkg;

    // Sequencer states: wait for PLL lock, count the lock hold-off, run the core.
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } clk_state_t;

    // Defaults for the 14.75 MHz system clock.
    localparam int LOCK_HOLD_DEF = 1024;
    localparam int PIX_DIV_DEF   = 2;
    localparam int CPU_DIV_DEF   = 7;

endpackage

// File: rtl/clk_en_reset_gen_sync2.sv
// Two-flop synchroniser bringing an asynchronous level into the clk_sys domain.
module sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Shift the async input through two flops; both clear on block reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/clk_en_reset_gen.sv
// Qualifies PLL lock, sequences the core reset release and derives the pixel
// and CPU clock enables from the single system clock.
module clk_en_reset_gen
    import blockade_clk_pkg::*;
#(
    parameter int LOCK_HOLD = LOCK_HOLD_DEF,
    parameter int PIX_DIV   = PIX_DIV_DEF,
    parameter int CPU_DIV   = CPU_DIV_DEF
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic pll_locked,
    input  logic soft_rst,
    output logic core_rst_n,
    output logic ce_pix,
    output logic ce_cpu,
    output logic locked_q
);

    localparam int HOLD_W = $clog2(LOCK_HOLD + 1);
    localparam int PIX_W  = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int CPU_W  = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);
    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIX_DIV - 1);
    localparam logic [CPU_W-1:0]  CPU_LAST  = CPU_W'(CPU_DIV - 1);

    clk_state_t        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [CPU_W-1:0]  cpu_q, cpu_d;
    logic              run_stay;

    sync2 u_lock_sync (
        .clk     (clk_sys),
        .reset_n (reset_n),
        .d       (pll_locked),
        .q       (locked_q)
    );

    // Next-state and hold counter; lock loss always outranks a soft restart.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            WAIT_LOCK: begin
                if (locked_q) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end
            end
            HOLD: begin
                if (!locked_q) begin
                    state_d = WAIT_LOCK;
                end else if (soft_rst) begin
                    hold_d = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            RUN: begin
                if (!locked_q) begin
                    state_d = WAIT_LOCK;
                end else if (soft_rst) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                hold_d  = '0;
            end
        endcase
    end

    // Dividers only advance while staying in RUN, so each RUN entry starts at phase 0.
    always_comb begin
        run_stay = (state_q == RUN) && (state_d == RUN);
        pix_d    = '0;
        cpu_d    = '0;
        if (run_stay) begin
            pix_d = (pix_q == PIX_LAST) ? '0 : pix_q + 1'b1;
            cpu_d = (cpu_q == CPU_LAST) ? '0 : cpu_q + 1'b1;
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q <= WAIT_LOCK;
            hold_q  <= '0;
            pix_q   <= '0;
            cpu_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            pix_q   <= pix_d;
            cpu_q   <= cpu_d;
        end
    end

    assign core_rst_n = (state_q == RUN);
    assign ce_pix     = (state_q == RUN) && (pix_q == PIX_LAST);
    assign ce_cpu     = (state_q == RUN) && (cpu_q == CPU_LAST);

endmodule

// File: tb/tb_clk_en_reset_gen.sv
// Directed bench for clk_en_reset_gen with LOCK_HOLD=8, PIX_DIV=2, CPU_DIV=7.
module tb_clk_en_reset_gen;

    localparam int LOCK_HOLD = 8;
    localparam int PIX_DIV   = 2;
    localparam int CPU_DIV   = 7;
    localparam int REL_EDGE  = LOCK_HOLD + 3;

    logic clk_sys    = 1'b0;
    logic reset_n    = 1'b0;
    logic pll_locked = 1'b0;
    logic soft_rst   = 1'b0;
    logic core_rst_n;
    logic ce_pix;
    logic ce_cpu;
    logic locked_q;

    int assert_count = 0;
    int fail_count   = 0;
    int run_k        = 0;

    clk_en_reset_gen #(
        .LOCK_HOLD (LOCK_HOLD),
        .PIX_DIV   (PIX_DIV),
        .CPU_DIV   (CPU_DIV)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .soft_rst   (soft_rst),
        .core_rst_n (core_rst_n),
        .ce_pix     (ce_pix),
        .ce_cpu     (ce_cpu),
        .locked_q   (locked_q)
    );

    // Free-running system clock.
    always #5 clk_sys = ~clk_sys;

    // Compare one observed value against its expected value and tally the result.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one active edge and settle just after it.
    task automatic applyStimulus();
        @(posedge clk_sys);
        #1;
    endtask

    // Expect every output low.
    task automatic checkAllLow(input string tag);
        checkOutput({tag, ".core_rst_n"}, 32'(core_rst_n), 32'd0);
        checkOutput({tag, ".ce_pix"}, 32'(ce_pix), 32'd0);
        checkOutput({tag, ".ce_cpu"}, 32'(ce_cpu), 32'd0);
    endtask

    // pll_locked is already high and the pipeline is clean: release lands on edge REL_EDGE.
    task automatic releaseSeq(input string tag, input bit check_lock);
        for (int e = 1; e <= REL_EDGE; e++) begin
            applyStimulus();
            checkOutput({tag, ".core_rst_n"}, 32'(core_rst_n), (e == REL_EDGE) ? 32'd1 : 32'd0);
            if (check_lock && e <= 3)
                checkOutput({tag, ".locked_q"}, 32'(locked_q), (e >= 2) ? 32'd1 : 32'd0);
        end
        checkOutput({tag, ".ce_pix0"}, 32'(ce_pix), 32'd0);
        checkOutput({tag, ".ce_cpu0"}, 32'(ce_cpu), 32'd0);
        run_k = 0;
    endtask

    // Stay in RUN for n edges and compare the enable cadence against the phase model.
    task automatic runCycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus();
            run_k++;
            checkOutput({tag, ".core_rst_n"}, 32'(core_rst_n), 32'd1);
            checkOutput({tag, ".ce_pix"}, 32'(ce_pix), ((run_k % PIX_DIV) == PIX_DIV - 1) ? 32'd1 : 32'd0);
            checkOutput({tag, ".ce_cpu"}, 32'(ce_cpu), ((run_k % CPU_DIV) == CPU_DIV - 1) ? 32'd1 : 32'd0);
        end
    endtask

    // Directed test sequence.
    initial begin
        #1;
        // 1: reset held with lock already high
        reset_n    = 1'b0;
        pll_locked = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkAllLow("reset");
            checkOutput("reset.locked_q", 32'(locked_q), 32'd0);
        end

        // 2: release and enable cadence
        reset_n = 1'b1;
        releaseSeq("release", 1'b1);
        runCycles("release_run", 21);

        // 3: lock glitch during hold restarts the count
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        applyStimulus();
        applyStimulus();
        reset_n    = 1'b1;
        pll_locked = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("glitch_hi.core_rst_n", 32'(core_rst_n), 32'd0);
        end
        pll_locked = 1'b0;
        applyStimulus();
        checkOutput("glitch_lo.core_rst_n", 32'(core_rst_n), 32'd0);
        pll_locked = 1'b1;
        releaseSeq("glitch_rel", 1'b0);
        runCycles("glitch_run", 9);

        // 4: lock loss while running
        pll_locked = 1'b0;
        runCycles("loss_pipe", 2);
        applyStimulus();
        checkAllLow("loss");
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            checkAllLow("loss_hold");
            checkOutput("loss_hold.locked_q", 32'(locked_q), 32'd0);
        end
        pll_locked = 1'b1;
        releaseSeq("relock", 1'b1);
        runCycles("relock_run", 8);

        // 5: soft restart pulse in RUN
        soft_rst = 1'b1;
        applyStimulus();
        soft_rst = 1'b0;
        checkAllLow("soft");
        for (int e = 1; e <= LOCK_HOLD; e++) begin
            applyStimulus();
            checkOutput("soft_hold.core_rst_n", 32'(core_rst_n), (e == LOCK_HOLD) ? 32'd1 : 32'd0);
        end
        run_k = 0;
        runCycles("soft_run", 8);

        // 5b: soft restart coinciding with lock loss goes back to lock wait
        pll_locked = 1'b0;
        runCycles("softloss_pipe", 2);
        soft_rst = 1'b1;
        applyStimulus();
        soft_rst = 1'b0;
        checkAllLow("softloss");
        checkOutput("softloss.locked_q", 32'(locked_q), 32'd0);

        // 5c: soft restart during HOLD clears the hold count
        pll_locked = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            applyStimulus();
            checkOutput("holdsoft_pre.core_rst_n", 32'(core_rst_n), 32'd0);
        end
        soft_rst = 1'b1;
        applyStimulus();
        soft_rst = 1'b0;
        checkOutput("holdsoft.core_rst_n", 32'(core_rst_n), 32'd0);
        for (int e = 1; e <= LOCK_HOLD; e++) begin
            applyStimulus();
            checkOutput("holdsoft_rel.core_rst_n", 32'(core_rst_n), (e == LOCK_HOLD) ? 32'd1 : 32'd0);
        end
        run_k = 0;
        runCycles("holdsoft_run", 4);

        // 6: one-edge block reset while running
        reset_n = 1'b0;
        applyStimulus();
        checkAllLow("midreset");
        checkOutput("midreset.locked_q", 32'(locked_q), 32'd0);
        reset_n = 1'b1;
        releaseSeq("midreset_rel", 1'b1);
        runCycles("midreset_run", 14);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
